serial_add_arbiter: RTL

Bit-serial adder controller that time-shares a single 1-bit full-add datapath between two requesters. The datapath is built from two half-adder stages plus an OR. The block accepts WIDTH-bit operand pairs over a req/gnt handshake and arbitrates round-robin when both requesters ask at once. It sequences the operands LSB-first through the shared datapath over WIDTH cycles and returns a registered WIDTH-bit sum plus carry-out with a one-cycle done pulse. It sits between operand producers and the shared adder, replacing per-requester parallel adders.

---
 rtl/serial_add_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/serial_add_arbiter.sv
// Bit-serial adder shared between two round-robin requesters.
// Operands are added LSB-first, one bit per cycle, through a single full-add datapath.
module serial_add_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_q;
    logic             carry_q;
    logic [CntW-1:0]  cnt_q;
    logic             owner_q;
    logic             last_id_q;

    // Shared datapath: two half adders and an OR form one full-add bit.
    logic p, g1, s, g2, carry_next;
    logic [WIDTH-1:0] res_next;

    always_comb begin
        p          = a_sh_q[0] ^ b_sh_q[0];
        g1         = a_sh_q[0] & b_sh_q[0];
        s          = p ^ carry_q;
        g2         = p & carry_q;
        carry_next = g1 | g2;
        res_next   = {s, res_q[WIDTH-1:1]};
    end

    // Requester 0 wins unless only requester 1 asks, or both ask and 0 was served last.
    logic pick1;
    assign pick1 = req1 && (!req0 || !last_id_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            res_q     <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            owner_q   <= 1'b0;
            last_id_q <= 1'b1;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            done_id   <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req0 || req1) begin
                        a_sh_q    <= pick1 ? a1 : a0;
                        b_sh_q    <= pick1 ? b1 : b0;
                        res_q     <= '0;
                        carry_q   <= 1'b0;
                        cnt_q     <= '0;
                        owner_q   <= pick1;
                        last_id_q <= pick1;
                        gnt0      <= !pick1;
                        gnt1      <= pick1;
                        busy      <= 1'b1;
                        state_q   <= StRun;
                    end
                end
                StRun: begin
                    gnt0    <= 1'b0;
                    gnt1    <= 1'b0;
                    a_sh_q  <= a_sh_q >> 1;
                    b_sh_q  <= b_sh_q >> 1;
                    res_q   <= res_next;
                    carry_q <= carry_next;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LastBit) begin
                        sum     <= res_next;
                        cout    <= carry_next;
                        done_id <= owner_q;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    carry_q <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
